flexbex_ibex_irq_ctrl: RTL

Machine-level interrupt controller directly upstream of the core controller and CSR file. It synchronises external interrupt lines and latches them as pending. It masks pending lines with a local enable register and the core's global MIE bit (m_irq_enable_i, driven from mstatus.MIE). It then presents one prioritised request plus a ready-made mcause value that the controller forwards as csr_cause on csr_save_cause.

---
 rtl/flexbex_ibex_irq_pkg.sv | 21 ++
 rtl/flexbex_ibex_irq_sync.sv | 28 ++
 rtl/flexbex_ibex_irq_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/flexbex_ibex_irq_pkg.sv
// flexbex_ibex_irq_pkg: shared definitions for the machine-level interrupt
// controller.
// Contents:
//   - cfg register addresses (ENABLE / PENDING w1c / SET w1s)
//   - controller FSM state type
//   - bit position of the interrupt flag inside mcause
package flexbex_ibex_irq_pkg;

  localparam logic [1:0] IRQ_CFG_ENABLE  = 2'd0;
  localparam logic [1:0] IRQ_CFG_PENDING = 2'd1;
  localparam logic [1:0] IRQ_CFG_SET     = 2'd2;

  localparam int unsigned IRQ_CAUSE_INT_BIT = 5;

  typedef enum logic [1:0] {
    IRQ_ST_IDLE = 2'd0,
    IRQ_ST_REQ  = 2'd1,
    IRQ_ST_HOLD = 2'd2
  } irq_state_e;

endpackage

// File: rtl/flexbex_ibex_irq_sync.sv
// flexbex_ibex_irq_sync: SYNC_STAGES-deep single-bit flop synchroniser for
// one asynchronous interrupt line.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (flops clear to 0)
//   i_d        : asynchronous input
//   o_q        : synchronised output (last stage)
module flexbex_ibex_irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/flexbex_ibex_irq_ctrl.sv
// flexbex_ibex_irq_ctrl: machine-level interrupt controller feeding the core
// controller / CSR file. Synchronises and latches external lines, masks them
// with a local enable register and mstatus.MIE, and presents one prioritised
// request (lowest index wins) with a ready-made mcause value.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   irq_i           : raw asynchronous interrupt lines
//   m_irq_enable_i  : global machine interrupt enable (mstatus.MIE)
//   cfg_we_i/addr_i/wdata_i : config writes (ENABLE, PENDING w1c, SET w1s)
//   cfg_rdata_o     : combinational read of cfg_addr_i
//   irq_req_o       : registered request to controller
//   irq_id_o        : registered id, frozen while irq_req_o=1
//   irq_cause_o     : {1'b1, irq_id_o}
//   irq_ack_i       : controller accepted the request
module flexbex_ibex_irq_ctrl
  import flexbex_ibex_irq_pkg::*;
#(
  parameter int unsigned N_IRQ       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] EDGE_MASK   = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             m_irq_enable_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [31:0]      cfg_wdata_i,
  output logic [31:0]      cfg_rdata_o,
  output logic             irq_req_o,
  output logic [4:0]       irq_id_o,
  output logic [5:0]       irq_cause_o,
  input  logic             irq_ack_i
);

  localparam logic [31:0] VALID_MASK  = (N_IRQ >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'h1 << N_IRQ) - 32'h1);
  localparam logic [31:0] EDGE_LINES  = EDGE_MASK & VALID_MASK;
  localparam logic [31:0] LEVEL_LINES = ~EDGE_MASK & VALID_MASK;

  irq_state_e  r_state, w_state_nxt;
  logic [4:0]  r_id, w_id_nxt, w_win_id;
  logic        w_found;
  logic [31:0] w_sync, r_sync_prev, r_pend_edge, r_enable;
  logic [31:0] w_pend, w_active, w_rise, w_set, w_clr, w_pend_edge_nxt;
  logic        w_wr_enable, w_wr_pend, w_wr_set, w_ack_take;
  logic [5:0]  w_cause;

  for (genvar k = 0; k < 32; k++) begin : g_line
    if (k < N_IRQ) begin : g_sync
      flexbex_ibex_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (irq_i[k]),
        .o_q   (w_sync[k])
      );
    end else begin : g_tie
      assign w_sync[k] = 1'b0;
    end
  end

  assign w_wr_enable = cfg_we_i && (cfg_addr_i == IRQ_CFG_ENABLE);
  assign w_wr_pend   = cfg_we_i && (cfg_addr_i == IRQ_CFG_PENDING);
  assign w_wr_set    = cfg_we_i && (cfg_addr_i == IRQ_CFG_SET);
  assign w_ack_take  = (r_state == IRQ_ST_REQ) && irq_ack_i;

  // Level lines bypass the latch: their pending view is the synchronised line.
  assign w_rise   = w_sync & ~r_sync_prev & EDGE_LINES;
  assign w_pend   = (r_pend_edge & EDGE_LINES) | (w_sync & LEVEL_LINES);
  assign w_active = m_irq_enable_i ? (w_pend & r_enable) : '0;

  // Set is applied after clear so a fresh edge in the clearing cycle survives.
  assign w_set = w_rise | (w_wr_set ? cfg_wdata_i : '0);
  assign w_clr = (w_wr_pend ? cfg_wdata_i : '0) | (w_ack_take ? (32'h1 << r_id) : '0);
  assign w_pend_edge_nxt = ((r_pend_edge & ~w_clr) | w_set) & EDGE_LINES;

  always_comb begin
    w_win_id = '0;
    w_found  = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!w_found && w_active[i]) begin
        w_win_id = 5'(i);
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    case (r_state)
      IRQ_ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = IRQ_ST_REQ;
          w_id_nxt    = w_win_id;
        end
      end
      IRQ_ST_REQ: begin
        if (irq_ack_i) begin
          w_state_nxt = IRQ_ST_HOLD;
        end else if (!w_active[r_id]) begin
          w_state_nxt = IRQ_ST_IDLE;
        end
      end
      IRQ_ST_HOLD: w_state_nxt = IRQ_ST_IDLE;
      default:     w_state_nxt = IRQ_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IRQ_ST_IDLE;
      r_id        <= '0;
      r_sync_prev <= '0;
      r_pend_edge <= '0;
      r_enable    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_id        <= w_id_nxt;
      r_sync_prev <= w_sync;
      r_pend_edge <= w_pend_edge_nxt;
      if (w_wr_enable) begin
        r_enable <= cfg_wdata_i & VALID_MASK;
      end
    end
  end

  always_comb begin
    w_cause                    = '0;
    w_cause[IRQ_CAUSE_INT_BIT] = 1'b1;
    w_cause[4:0]               = r_id;
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      IRQ_CFG_ENABLE:  cfg_rdata_o = r_enable;
      IRQ_CFG_PENDING: cfg_rdata_o = w_pend;
      default:         cfg_rdata_o = '0;
    endcase
  end

  assign irq_req_o   = (r_state == IRQ_ST_REQ);
  assign irq_id_o    = r_id;
  assign irq_cause_o = w_cause;

endmodule
